pll_lock_sequencer: RTL and testbench

//   Start-up and supervision controller for the pll2x clock multiplier. Pulses the PLL

---
 rtl/pll_lock_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_pll_lock_sequencer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_sequencer.sv
// rtl/pll_lock_sequencer.sv - PLL start-up and lock supervision sequencer
//
// Purpose: pulses the PLL reset, waits for lock, qualifies lock as stable, then
// releases the system reset. Sustained loss of lock (or a relock request) drops
// the system reset and re-sequences. Lock losses and lock timeouts are counted.
//
// Ports:
//   inclock      in   reference clock, clocks all logic here
//   rst_n        in   asynchronous active-low reset
//   locked       in   PLL lock flag (asynchronous, synchronised internally)
//   relock_req   in   single-cycle pulse, force full re-sequence
//   clr_cnt      in   single-cycle pulse, clear both event counters
//   pll_areset   out  PLL reset, active-high
//   sys_rst_n    out  system reset, active-low, released only in RUN
//   pll_ok       out  high only in RUN
//   seq_state    out  00 RESET_PLL, 01 WAIT_LOCK, 10 STABLE, 11 RUN
//   loss_cnt     out  saturating count of lock losses in RUN
//   timeout_cnt  out  saturating count of WAIT_LOCK timeouts

module pll_lock_sequencer #(
    parameter int ARESET_CYCLES = 16,
    parameter int LOCK_TIMEOUT  = 4096,
    parameter int STABLE_CYCLES = 1024,
    parameter int GLITCH_CYCLES = 4,
    parameter int TMR_W         = 16,
    parameter int CNT_W         = 8
) (
    input  logic             inclock,
    input  logic             rst_n,
    input  logic             locked,
    input  logic             relock_req,
    input  logic             clr_cnt,
    output logic             pll_areset,
    output logic             sys_rst_n,
    output logic             pll_ok,
    output logic [1:0]       seq_state,
    output logic [CNT_W-1:0] loss_cnt,
    output logic [CNT_W-1:0] timeout_cnt
);

    typedef enum logic [1:0] {
        S_RESET_PLL = 2'b00,
        S_WAIT_LOCK = 2'b01,
        S_STABLE    = 2'b10,
        S_RUN       = 2'b11
    } state_e;

    localparam logic [TMR_W-1:0] ARESET_LAST = TMR_W'(ARESET_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMO_LAST    = TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] STABLE_LAST = TMR_W'(STABLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] GLITCH_LAST = TMR_W'(GLITCH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    state_e           state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] loss_q, loss_d;
    logic [CNT_W-1:0] tmo_q, tmo_d;
    logic             sync1_q, sync2_q;
    logic             areset_q, areset_d;
    logic             sysrst_q, sysrst_d;
    logic             ok_q, ok_d;
    logic             loss_inc, tmo_inc;
    logic             lk;

    assign lk = sync2_q;

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        loss_inc = 1'b0;
        tmo_inc  = 1'b0;

        case (state_q)
            S_RESET_PLL: begin
                if (timer_q == ARESET_LAST) begin
                    state_d = S_WAIT_LOCK;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            S_WAIT_LOCK: begin
                if (lk) begin
                    state_d = S_STABLE;
                    timer_d = '0;
                end else if (timer_q == TMO_LAST) begin
                    state_d = S_RESET_PLL;
                    timer_d = '0;
                    tmo_inc = 1'b1;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            S_STABLE: begin
                if (!lk) begin
                    state_d = S_WAIT_LOCK;
                    timer_d = '0;
                end else if (timer_q == STABLE_LAST) begin
                    state_d = S_RUN;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            S_RUN: begin
                // In RUN the timer counts consecutive unlocked cycles.
                if (lk) begin
                    timer_d = '0;
                end else if (timer_q == GLITCH_LAST) begin
                    state_d  = S_RESET_PLL;
                    timer_d  = '0;
                    loss_inc = 1'b1;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            default: begin
                state_d = S_RESET_PLL;
                timer_d = '0;
            end
        endcase

        // A relock request overrides whatever the state wanted, including
        // a same-cycle loss or timeout, and is never counted.
        if (relock_req) begin
            state_d  = S_RESET_PLL;
            timer_d  = '0;
            loss_inc = 1'b0;
            tmo_inc  = 1'b0;
        end

        loss_d = loss_q;
        if (clr_cnt) begin
            loss_d = '0;
        end else if (loss_inc && loss_q != CNT_MAX) begin
            loss_d = loss_q + CNT_W'(1);
        end

        tmo_d = tmo_q;
        if (clr_cnt) begin
            tmo_d = '0;
        end else if (tmo_inc && tmo_q != CNT_MAX) begin
            tmo_d = tmo_q + CNT_W'(1);
        end

        // Outputs decoded from the next state so they change on the same edge.
        areset_d = (state_d == S_RESET_PLL);
        sysrst_d = (state_d == S_RUN);
        ok_d     = (state_d == S_RUN);
    end

    always_ff @(posedge inclock or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_RESET_PLL;
            timer_q  <= '0;
            loss_q   <= '0;
            tmo_q    <= '0;
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            areset_q <= 1'b1;
            sysrst_q <= 1'b0;
            ok_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            loss_q   <= loss_d;
            tmo_q    <= tmo_d;
            sync1_q  <= locked;
            sync2_q  <= sync1_q;
            areset_q <= areset_d;
            sysrst_q <= sysrst_d;
            ok_q     <= ok_d;
        end
    end

    assign pll_areset  = areset_q;
    assign sys_rst_n   = sysrst_q;
    assign pll_ok      = ok_q;
    assign seq_state   = state_q;
    assign loss_cnt    = loss_q;
    assign timeout_cnt = tmo_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb/tb_pll_lock_sequencer.sv - self-checking bench for pll_lock_sequencer

module tb_pll_lock_sequencer;

    localparam int AR  = 16;
    localparam int LT  = 4096;
    localparam int ST  = 1024;
    localparam int GC  = 4;
    // locked -> sys_rst_n: two synchroniser edges, one edge for WAIT_LOCK to see lk
    localparam int LAT = 3;

    localparam int S_AR = 4;
    localparam int S_LT = 8;
    localparam int S_ST = 32;

    logic       clk = 1'b0;
    logic       rst_n, locked, relock_req, clr_cnt;
    logic       pll_areset, sys_rst_n, pll_ok;
    logic [1:0] seq_state;
    logic [7:0] loss_cnt, timeout_cnt;

    logic       s_rst_n, s_locked, s_relock, s_clr;
    logic       s_pll_areset, s_sys_rst_n, s_pll_ok;
    logic [1:0] s_seq_state, s_loss_cnt, s_timeout_cnt;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    logic mon     = 1'b0;
    logic sys_seen = 1'b0;

    pll_lock_sequencer u_dut (
        .inclock    (clk),
        .rst_n      (rst_n),
        .locked     (locked),
        .relock_req (relock_req),
        .clr_cnt    (clr_cnt),
        .pll_areset (pll_areset),
        .sys_rst_n  (sys_rst_n),
        .pll_ok     (pll_ok),
        .seq_state  (seq_state),
        .loss_cnt   (loss_cnt),
        .timeout_cnt(timeout_cnt)
    );

    pll_lock_sequencer #(
        .ARESET_CYCLES(S_AR), .LOCK_TIMEOUT(S_LT), .STABLE_CYCLES(S_ST),
        .GLITCH_CYCLES(2), .TMR_W(8), .CNT_W(2)
    ) u_small (
        .inclock    (clk),
        .rst_n      (s_rst_n),
        .locked     (s_locked),
        .relock_req (s_relock),
        .clr_cnt    (s_clr),
        .pll_areset (s_pll_areset),
        .sys_rst_n  (s_sys_rst_n),
        .pll_ok     (s_pll_ok),
        .seq_state  (s_seq_state),
        .loss_cnt   (s_loss_cnt),
        .timeout_cnt(s_timeout_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (mon && sys_rst_n) sys_seen <= 1'b1;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic sig(input int sel);
        if (sel == 0) return pll_areset;
        return sys_rst_n;
    endfunction

    // Ticks until the selected output equals val; n = ticks taken, -1 if bound expired.
    task automatic wait_for(input int sel, input logic val, input int bound, output int n);
        n = 0;
        while (sig(sel) !== val && n < bound) begin
            tick(1);
            n++;
        end
        if (sig(sel) !== val) n = -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; s_rst_n = 1'b0;
        locked = 1'b0; s_locked = 1'b0;
        relock_req = 1'b0; clr_cnt = 1'b0; s_relock = 1'b0; s_clr = 1'b0;
        tick(3);
        n_tests++; if (pll_areset !== 1'b1) begin n_fail++; $display("FAIL reset_areset: got %b want 1", pll_areset); end
        n_tests++; if (sys_rst_n !== 1'b0) begin n_fail++; $display("FAIL reset_sys_rst_n: got %b want 0", sys_rst_n); end
        n_tests++; if (pll_ok !== 1'b0) begin n_fail++; $display("FAIL reset_pll_ok: got %b want 0", pll_ok); end
        n_tests++; if (seq_state !== 2'b00) begin n_fail++; $display("FAIL reset_state: got %0d want 0", seq_state); end
        n_tests++; if (loss_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_loss: got %0d want 0", loss_cnt); end
        n_tests++; if (timeout_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_timeout: got %0d want 0", timeout_cnt); end
        n_tests++; if (s_pll_areset !== 1'b1) begin n_fail++; $display("FAIL reset_small_areset: got %b want 1", s_pll_areset); end
    endtask

    task automatic test_powerup();
        int n, d;
        rst_n = 1'b1;
        wait_for(0, 1'b0, 200, n);
        n_tests++; if (n != AR) begin n_fail++; $display("FAIL powerup_areset_len: got %0d want %0d", n, AR); end
        d = $urandom_range(60, 140);
        tick(d);
        n_tests++; if (seq_state !== 2'b01) begin n_fail++; $display("FAIL powerup_wait_state: got %0d want 1", seq_state); end
        locked = 1'b1;
        wait_for(1, 1'b1, ST + 100, n);
        n_tests++; if (n != LAT + ST) begin n_fail++; $display("FAIL powerup_release_delay: got %0d want %0d", n, LAT + ST); end
        n_tests++; if (pll_ok !== 1'b1 || seq_state !== 2'b11) begin n_fail++; $display("FAIL powerup_run: got ok=%b state=%0d want ok=1 state=3", pll_ok, seq_state); end
        n_tests++; if (pll_areset !== 1'b0) begin n_fail++; $display("FAIL powerup_areset_run: got %b want 0", pll_areset); end
    endtask

    task automatic test_run_glitch();
        int n, len, d;
        logic ok;
        for (int k = 0; k < 2; k++) begin
            len = $urandom_range(1, GC - 1);
            locked = 1'b0;
            ok = 1'b1;
            for (int i = 0; i < len + 8; i++) begin
                if (i == len) locked = 1'b1;
                tick(1);
                if (sys_rst_n !== 1'b1 || pll_ok !== 1'b1) ok = 1'b0;
            end
            n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL short_glitch_len%0d: got run_dropped want run_held", len); end
        end
        locked = 1'b0;
        wait_for(1, 1'b0, 50, n);
        n_tests++; if (n != GC + 2) begin n_fail++; $display("FAIL loss_delay: got %0d want %0d", n, GC + 2); end
        n_tests++; if (loss_cnt !== 8'd1) begin n_fail++; $display("FAIL loss_cnt: got %0d want 1", loss_cnt); end
        n_tests++; if (pll_areset !== 1'b1 || pll_ok !== 1'b0 || seq_state !== 2'b00) begin n_fail++; $display("FAIL loss_outputs: got areset=%b ok=%b state=%0d want 1 0 0", pll_areset, pll_ok, seq_state); end
        wait_for(0, 1'b0, 100, n);
        n_tests++; if (n != AR) begin n_fail++; $display("FAIL relock_areset_len: got %0d want %0d", n, AR); end
        d = $urandom_range(20, 200);
        tick(d);
        locked = 1'b1;
        wait_for(1, 1'b1, ST + 100, n);
        n_tests++; if (n != LAT + ST) begin n_fail++; $display("FAIL relock_release_delay: got %0d want %0d", n, LAT + ST); end
    endtask

    task automatic test_relock_priority();
        int n, d;
        locked = 1'b0;
        tick(GC + 1);
        relock_req = 1'b1; tick(1); relock_req = 1'b0;
        n_tests++; if (seq_state !== 2'b00 || sys_rst_n !== 1'b0) begin n_fail++; $display("FAIL relock_vs_loss_state: got state=%0d sys=%b want 0 0", seq_state, sys_rst_n); end
        n_tests++; if (loss_cnt !== 8'd1) begin n_fail++; $display("FAIL relock_vs_loss_cnt: got %0d want 1", loss_cnt); end
        wait_for(0, 1'b0, 100, n);
        n_tests++; if (n != AR) begin n_fail++; $display("FAIL relock_areset_len1: got %0d want %0d", n, AR); end
        d = $urandom_range(5, 50);
        tick(d);
        relock_req = 1'b1; tick(1); relock_req = 1'b0;
        n_tests++; if (seq_state !== 2'b00 || pll_areset !== 1'b1 || timeout_cnt !== 8'd0) begin n_fail++; $display("FAIL relock_in_wait: got state=%0d areset=%b tmo=%0d want 0 1 0", seq_state, pll_areset, timeout_cnt); end
        wait_for(0, 1'b0, 100, n);
        n_tests++; if (n != AR) begin n_fail++; $display("FAIL relock_areset_len2: got %0d want %0d", n, AR); end
        locked = 1'b1;
        d = $urandom_range(10, 500);
        tick(LAT + d);
        n_tests++; if (seq_state !== 2'b10) begin n_fail++; $display("FAIL stable_reached: got %0d want 2", seq_state); end
        relock_req = 1'b1; tick(1); relock_req = 1'b0;
        n_tests++; if (seq_state !== 2'b00 || pll_areset !== 1'b1 || loss_cnt !== 8'd1) begin n_fail++; $display("FAIL relock_in_stable: got state=%0d areset=%b loss=%0d want 0 1 1", seq_state, pll_areset, loss_cnt); end
        locked = 1'b0;
        clr_cnt = 1'b1; tick(1); clr_cnt = 1'b0;
        n_tests++; if (loss_cnt !== 8'd0) begin n_fail++; $display("FAIL clr_loss: got %0d want 0", loss_cnt); end
    endtask

    task automatic test_stable_glitch();
        int n, d, g, c2;
        rst_n = 1'b0; tick(1); rst_n = 1'b1;
        wait_for(0, 1'b0, 100, n);
        n_tests++; if (n != AR) begin n_fail++; $display("FAIL sg_areset_len: got %0d want %0d", n, AR); end
        d = $urandom_range(10, 100);
        tick(d);
        locked = 1'b1;
        g = $urandom_range(100, 900);
        tick(1 + g);
        locked = 1'b0; tick(1); locked = 1'b1;
        c2 = cyc;
        tick(2);
        n_tests++; if (seq_state !== 2'b01) begin n_fail++; $display("FAIL sg_back_to_wait: got %0d want 1", seq_state); end
        wait_for(1, 1'b1, ST + 100, n);
        n_tests++; if (n < 0 || cyc - c2 != LAT + ST) begin n_fail++; $display("FAIL sg_requalify: got %0d want %0d", cyc - c2, LAT + ST); end
        n_tests++; if (loss_cnt !== 8'd0 || timeout_cnt !== 8'd0) begin n_fail++; $display("FAIL sg_counters: got loss=%0d tmo=%0d want 0 0", loss_cnt, timeout_cnt); end
        #3;
        rst_n = 1'b0;
        #1;
        n_tests++; if (sys_rst_n !== 1'b0 || pll_ok !== 1'b0 || pll_areset !== 1'b1 || seq_state !== 2'b00) begin n_fail++; $display("FAIL async_reset_run: got sys=%b ok=%b areset=%b state=%0d want 0 0 1 0", sys_rst_n, pll_ok, pll_areset, seq_state); end
        tick(1);
    endtask

    task automatic test_timeout_clr();
        int n;
        locked = 1'b0;
        sys_seen = 1'b0;
        mon = 1'b1;
        rst_n = 1'b1;
        wait_for(0, 1'b0, 100, n);
        n_tests++; if (n != AR) begin n_fail++; $display("FAIL to_areset_first: got %0d want %0d", n, AR); end
        for (int i = 1; i <= 3; i++) begin
            wait_for(0, 1'b1, LT + 100, n);
            n_tests++; if (n != LT) begin n_fail++; $display("FAIL to_wait_len%0d: got %0d want %0d", i, n, LT); end
            n_tests++; if (timeout_cnt !== 8'(i)) begin n_fail++; $display("FAIL to_count%0d: got %0d want %0d", i, timeout_cnt, i); end
            wait_for(0, 1'b0, 100, n);
            n_tests++; if (n != AR) begin n_fail++; $display("FAIL to_areset_len%0d: got %0d want %0d", i, n, AR); end
        end
        tick(LT - 1);
        clr_cnt = 1'b1; tick(1); clr_cnt = 1'b0;
        n_tests++; if (pll_areset !== 1'b1) begin n_fail++; $display("FAIL clr_at_timeout_edge: got %b want 1", pll_areset); end
        n_tests++; if (timeout_cnt !== 8'd0) begin n_fail++; $display("FAIL clr_beats_increment: got %0d want 0", timeout_cnt); end
        mon = 1'b0;
        n_tests++; if (sys_seen !== 1'b0) begin n_fail++; $display("FAIL to_sys_rst_n_held: got released want held"); end
    endtask

    task automatic test_small();
        int r, expv;
        s_rst_n = 1'b1;
        r = cyc;
        for (int k = 1; k <= 5; k++) begin
            while (cyc < r + k * (S_AR + S_LT)) tick(1);
            expv = (k < 3) ? k : 3;
            n_tests++; if (s_timeout_cnt !== 2'(expv)) begin n_fail++; $display("FAIL small_sat%0d: got %0d want %0d", k, s_timeout_cnt, expv); end
        end
        s_locked = 1'b1;
        tick(13);
        n_tests++; if (s_seq_state !== 2'b10) begin n_fail++; $display("FAIL small_stable: got %0d want 2", s_seq_state); end
        #3;
        s_rst_n = 1'b0;
        #1;
        n_tests++; if (s_seq_state !== 2'b00 || s_pll_areset !== 1'b1 || s_sys_rst_n !== 1'b0 || s_pll_ok !== 1'b0) begin n_fail++; $display("FAIL small_async_outputs: got state=%0d areset=%b sys=%b ok=%b want 0 1 0 0", s_seq_state, s_pll_areset, s_sys_rst_n, s_pll_ok); end
        n_tests++; if (s_timeout_cnt !== 2'd0 || s_loss_cnt !== 2'd0) begin n_fail++; $display("FAIL small_async_counters: got tmo=%0d loss=%0d want 0 0", s_timeout_cnt, s_loss_cnt); end
        tick(1);
    endtask

    initial begin
        test_reset();
        test_powerup();
        test_run_glitch();
        test_relock_priority();
        test_stable_glitch();
        test_timeout_clr();
        test_small();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #700000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
